fifo_read_port: RTL and testbench

// - Read-side controller for the FIFO built on DualPortRam. Owns the read pointer,

---
 rtl/fifo_defs.sv | 14 +
 rtl/fifo_read_port.sv | 67 ++++++
 tb/tb_fifo_read_port.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_defs.sv
// Shared FIFO definitions: default widths and the output-stage state encoding.
// The write-side controller uses the same header.
package fifo_defs;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 8;
    localparam int PTR_W           = FIFO_ADDR_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } ostate_t;

endpackage

// File: rtl/fifo_read_port.sv
// FIFO read-side controller: owns rd_ptr, drives RAM port 0 (combinational read)
// and presents the head word from a one-entry output register on a valid/ready stream.
module fifo_read_port
    import fifo_defs::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);

    ostate_t state, state_next;
    logic    load;

    // Pointers carry a wrap bit, so equality means empty and the difference
    // reaches 2**ADDR_WIDTH when the RAM is full.
    assign empty    = (rd_ptr == wr_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign ram_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign load     = !empty && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush)
            state_next = IDLE;
        else if (load)
            state_next = HOLD;
        else if (state == HOLD && out_ready)
            state_next = IDLE;
    end

    always_comb begin
        out_valid = (state == HOLD);
    end

    // Flush resyncs to the pre-edge wr_ptr, so a word written on the same edge survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            out_data <= '0;
        end else if (flush) begin
            rd_ptr   <= wr_ptr;
        end else if (load) begin
            rd_ptr   <= rd_ptr + 1'b1;
            out_data <= ram_data;
        end
    end

endmodule

// File: tb/tb_fifo_read_port.sv
// Directed bench for fifo_read_port: behavioural RAM + writer around a default-width
// instance and an ADDR_WIDTH=3 instance used for pointer-wrap streaming.
module tb_fifo_read_port;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- instance A: 8-bit address ----------------
    logic       we_a, ready_a, flush_a;
    logic [7:0] wd_a;
    logic [8:0] wr_ptr_a;
    logic [7:0] mem_a [256];
    logic [7:0] ram_addr_a, ram_data_a, out_data_a;
    logic [8:0] rd_ptr_a, level_a;
    logic       out_valid_a, empty_a;

    always @(posedge clk) begin
        if (rst)
            wr_ptr_a <= '0;
        else if (we_a) begin
            mem_a[wr_ptr_a[7:0]] <= wd_a;
            wr_ptr_a             <= wr_ptr_a + 9'd1;
        end
    end
    assign ram_data_a = mem_a[ram_addr_a];

    fifo_read_port #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut_a (
        .clk(clk), .reset(rst), .wr_ptr(wr_ptr_a), .ram_data(ram_data_a),
        .out_ready(ready_a), .flush(flush_a), .ram_addr(ram_addr_a), .rd_ptr(rd_ptr_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .empty(empty_a), .level(level_a)
    );

    // ---------------- instance B: 3-bit address, depth 8 ----------------
    logic       we_b, ready_b, flush_b;
    logic [7:0] wd_b;
    logic [3:0] wr_ptr_b;
    logic [7:0] mem_b [8];
    logic [2:0] ram_addr_b;
    logic [7:0] ram_data_b, out_data_b;
    logic [3:0] rd_ptr_b, level_b;
    logic       out_valid_b, empty_b;

    always @(posedge clk) begin
        if (rst)
            wr_ptr_b <= '0;
        else if (we_b) begin
            mem_b[wr_ptr_b[2:0]] <= wd_b;
            wr_ptr_b             <= wr_ptr_b + 4'd1;
        end
    end
    assign ram_data_b = mem_b[ram_addr_b];

    fifo_read_port #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut_b (
        .clk(clk), .reset(rst), .wr_ptr(wr_ptr_b), .ram_data(ram_data_b),
        .out_ready(ready_b), .flush(flush_b), .ram_addr(ram_addr_b), .rd_ptr(rd_ptr_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .empty(empty_b), .level(level_b)
    );

    initial begin
        rst = 1'b1;
        we_a = 0; wd_a = '0; ready_a = 0; flush_a = 0;
        we_b = 0; wd_b = '0; ready_b = 0; flush_b = 0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // reset state, no writes for 10 cycles
        check("rst_out_data", out_data_a, 8'h00);
        check("rst_rd_ptr", rd_ptr_a, 9'd0);
        for (int i = 0; i < 10; i++) begin
            check("idle_valid", out_valid_a, 1'b0);
            check("idle_empty", empty_a, 1'b1);
            check("idle_level", level_a, 9'd0);
            check("idle_addr", ram_addr_a, 8'd0);
            tick();
        end

        // single word latency
        ready_a = 1; we_a = 1; wd_a = 8'hA5;
        tick();
        we_a = 0;
        check("lat_valid_n", out_valid_a, 1'b0);
        check("lat_level_n", level_a, 9'd1);
        tick();
        check("lat_valid_n1", out_valid_a, 1'b1);
        check("lat_data_n1", out_data_a, 8'hA5);
        check("lat_rdptr", rd_ptr_a, 9'd1);
        check("lat_empty", empty_a, 1'b1);
        tick();
        check("lat_valid_n2", out_valid_a, 1'b0);

        // burst of 16 with backpressure, then drain
        ready_a = 0;
        for (int i = 1; i <= 16; i++) begin
            we_a = 1; wd_a = 8'(i);
            tick();
        end
        we_a = 0;
        check("bp_level", level_a, 9'd15);
        check("bp_rdptr", rd_ptr_a, 9'd2);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", out_valid_a, 1'b1);
            check("bp_hold", out_data_a, 8'h01);
            tick();
        end
        ready_a = 1;
        for (int k = 2; k <= 16; k++) begin
            tick();
            check("drain_valid", out_valid_a, 1'b1);
            check("drain_data", out_data_a, 32'(k));
        end
        tick();
        check("drain_done", out_valid_a, 1'b0);
        check("drain_rdptr", rd_ptr_a, 9'd17);

        // flush while holding
        ready_a = 0;
        for (int i = 0; i < 5; i++) begin
            we_a = 1; wd_a = 8'(8'h21 + i);
            tick();
        end
        we_a = 0;
        check("fl_pre_valid", out_valid_a, 1'b1);
        check("fl_pre_data", out_data_a, 8'h21);
        flush_a = 1;
        tick();
        flush_a = 0;
        check("fl_valid", out_valid_a, 1'b0);
        check("fl_rdptr", rd_ptr_a, 9'd22);
        check("fl_level", level_a, 9'd0);
        check("fl_empty", empty_a, 1'b1);

        // flush coinciding with a write keeps the new word
        for (int i = 0; i < 2; i++) begin
            we_a = 1; wd_a = 8'(8'h31 + i);
            tick();
        end
        check("fw_pre_data", out_data_a, 8'h31);
        we_a = 1; wd_a = 8'h77; flush_a = 1;
        tick();
        we_a = 0; flush_a = 0;
        check("fw_valid", out_valid_a, 1'b0);
        check("fw_rdptr", rd_ptr_a, 9'd24);
        check("fw_level", level_a, 9'd1);
        ready_a = 1;
        tick();
        check("fw_deliver_v", out_valid_a, 1'b1);
        check("fw_deliver_d", out_data_a, 8'h77);
        tick();
        check("fw_after", out_valid_a, 1'b0);
        check("fw_empty", empty_a, 1'b1);

        // reset while holding
        ready_a = 0;
        we_a = 1; wd_a = 8'h55;
        tick();
        we_a = 0;
        tick();
        check("rh_valid", out_valid_a, 1'b1);
        check("rh_data", out_data_a, 8'h55);
        rst = 1;
        tick();
        rst = 0;
        check("rh_valid0", out_valid_a, 1'b0);
        check("rh_rdptr", rd_ptr_a, 9'd0);
        check("rh_level", level_a, 9'd0);

        // depth-8 streaming with random ready across two wraps
        begin
            int wr_cnt, rd_cnt, cyc, max_lvl;
            wr_cnt = 0; rd_cnt = 0; cyc = 0; max_lvl = 0;
            while (rd_cnt < 20 && cyc < 500) begin
                if (32'(level_b) > max_lvl) max_lvl = 32'(level_b);
                // rd_ptr counts words delivered plus the one in the output stage
                check("wrap_rdptr", rd_ptr_b, 32'((rd_cnt + (out_valid_b ? 1 : 0)) % 16));
                ready_b = 1'($urandom_range(0, 1));
                if (wr_cnt < 20 && 4'(wr_ptr_b - rd_ptr_b) < 4'd8) begin
                    we_b = 1; wd_b = 8'(8'h40 + wr_cnt); wr_cnt++;
                end else begin
                    we_b = 0;
                end
                if (out_valid_b && ready_b) begin
                    check("wrap_data", out_data_b, 32'(8'h40 + rd_cnt));
                    rd_cnt++;
                end
                tick();
                cyc++;
            end
            we_b = 0;
            check("wrap_count", rd_cnt, 20);
            check("wrap_maxlvl_le8", (max_lvl <= 8), 1'b1);
            check("wrap_final_ptr", rd_ptr_b, 4'd4);
            check("wrap_final_empty", empty_b, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
